// File: rtl/param_counter_if.sv
// param_counter_if: control inputs and count/status outputs of param_counter.
interface param_counter_if #(parameter int WIDTH = 32);
    logic             en;
    logic             up_dn;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (output en, up_dn, clear, load, load_val, ovf_clr, input count, tc, ovf);
    modport slave  (input en, up_dn, clear, load, load_val, ovf_clr, output count, tc, ovf);
endinterface

// File: rtl/param_counter.sv
// param_counter: prescaled up/down counter over 0..MAX_VAL with wrap or saturate,
// registered terminal-count pulse and sticky range-end flag.
module param_counter #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               DIV      = 1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    param_counter_if.slave bus
);
    localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

    logic [15:0]      pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d, ovf_q, ovf_d;
    logic             do_step, at_end;
    logic [WIDTH-1:0] step_val, load_clamped;

    always_comb begin
        do_step      = !bus.clear && !bus.load && bus.en && pre_q == PRE_LAST;
        at_end       = bus.up_dn ? count_q == MAX_VAL : count_q == '0;
        // range ends either hold (saturate) or jump to the opposite end
        step_val     = bus.up_dn ? (at_end ? (SATURATE ? MAX_VAL : '0) : count_q + 1'b1)
                                 : (at_end ? (SATURATE ? '0 : MAX_VAL) : count_q - 1'b1);
        load_clamped = bus.load_val > MAX_VAL ? MAX_VAL : bus.load_val;
        pre_d        = (bus.clear || bus.load) ? '0 :
                       bus.en ? (pre_q == PRE_LAST ? '0 : pre_q + 1'b1) : pre_q;
        count_d      = bus.clear ? '0 : bus.load ? load_clamped : do_step ? step_val : count_q;
        tc_d         = do_step && at_end;
        ovf_d        = tc_d || (ovf_q && !bus.ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule
